// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the MIPS pipeline memory/write-back stage:
//   - opcode constants for the supported memory instructions
//   - write-back stage FSM state encoding
//   - memory-operation classification helper
// No ports (package).
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_LB      = 6'b100000;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SB      = 6'b101000;
    localparam logic [5:0] OP_SW      = 6'b101011;

    localparam logic [4:0] REG_ZERO   = 5'd0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WB     = 2'd2
    } wb_state_t;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_kind_t;

    // Only the four supported opcodes become bus accesses; any other opcode
    // carrying a memory flag falls back to a plain register-result op.
    // A load flag on a load opcode wins over a simultaneous store flag.
    function automatic mem_kind_t mem_kind(input logic [5:0] op,
                                           input logic       rd,
                                           input logic       wr);
        if (rd && (op == OP_LW || op == OP_LB))
            return MEM_LOAD;
        if (wr && (op == OP_SW || op == OP_SB))
            return MEM_STORE;
        return MEM_NONE;
    endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// ----------------------------------------------------------------------------
// mem_byte_lane
// Combinational little-endian byte-lane steering for the data-memory bus.
//   sb_op      in  1   store-byte: enable a single lane and replicate the byte
//   lb_op      in  1   load-byte: sign-extend the selected byte
//   offset     in  2   byte offset inside the word (lane k = bits [8k+7:8k])
//   store_data in  32  register value to store
//   rdata      in  32  word returned by memory
//   be         out 4   byte enables
//   wdata      out 32  bus write data
//   load_data  out 32  formatted register write-back value
// ----------------------------------------------------------------------------
module mem_byte_lane (
    input  logic        sb_op,
    input  logic        lb_op,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0] sel_byte;

    always_comb begin
        sel_byte = rdata[7:0];
        case (offset)
            2'd0:    sel_byte = rdata[7:0];
            2'd1:    sel_byte = rdata[15:8];
            2'd2:    sel_byte = rdata[23:16];
            default: sel_byte = rdata[31:24];
        endcase
    end

    // Byte stores replicate the byte on every lane so memory can pick it up
    // from whichever lane the enable selects.
    assign be        = sb_op ? (4'b0001 << offset) : 4'b1111;
    assign wdata     = sb_op ? {4{store_data[7:0]}} : store_data;
    assign load_data = lb_op ? {{24{sel_byte[7]}}, sel_byte} : rdata;

endmodule

// File: rtl/mem_wb_unit.sv
// ----------------------------------------------------------------------------
// mem_wb_unit
// Memory-access and write-back stage of the MIPS pipeline. Executes LW/LB/
// SW/SB over a single-outstanding req/ack bus and drives the register-file
// write port consumed by the decode stage.
//
// Optional build macro: MEM_ALIGN_CHECK_EN -- misaligned LW/SW are dropped
// and flagged on addr_err; otherwise addr_err is tied 0 and the low address
// bits of word ops are ignored.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_op/in_reg_write/in_mem_read/in_mem_write/in_dest/
//   in_result/in_store_data       instruction from EX
//   stall                         high while busy; EX must hold
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata   data-memory request
//   mem_rdata/mem_ack             data-memory response
//   reg_write/write_reg/write_data             register-file write port
//   addr_err                      misaligned word access (optional feature)
//
// EX handshake: an instruction transfers on a rising edge where in_valid=1
// and stall=0. stall is registered (stall = state != IDLE), so it rises the
// cycle after a memory op is accepted; EX holds its outputs while it is high.
// Memory handshake: mem_req and all bus fields stay stable until an edge
// with mem_ack=1; mem_ack is ignored while mem_req=0.
// ----------------------------------------------------------------------------
module mem_wb_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [5:0]        in_op,
    input  logic              in_reg_write,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic [4:0]        in_dest,
    input  logic [DATA_W-1:0] in_result,
    input  logic [DATA_W-1:0] in_store_data,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              reg_write,
    output logic [4:0]        write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic              addr_err
);

    wb_state_t         state_q, state_d;
    logic              stall_q, stall_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              reg_write_q, reg_write_d;
    logic [4:0]        write_reg_q, write_reg_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;

    // Latched context of the in-flight memory op.
    logic              lb_q, lb_d;
    logic [1:0]        off_q, off_d;
    logic [4:0]        dest_q, dest_d;

    mem_kind_t         kind;
    logic [1:0]        lane_off;
    logic              lane_sb;
    logic [3:0]        lane_be;
    logic [31:0]       lane_wdata;
    logic [31:0]       lane_load;

    assign kind = mem_kind(in_op, in_mem_read, in_mem_write);

    // In IDLE the lanes format the incoming store; afterwards they format
    // the returning load data using the latched offset.
    assign lane_off = (state_q == IDLE) ? in_result[1:0] : off_q;
    assign lane_sb  = (in_op == OP_SB);

    mem_byte_lane u_lane (
        .sb_op      (lane_sb),
        .lb_op      (lb_q),
        .offset     (lane_off),
        .store_data (in_store_data),
        .rdata      (mem_rdata),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .load_data  (lane_load)
    );

`ifdef MEM_ALIGN_CHECK_EN
    logic misaligned;
    logic addr_err_q;

    assign misaligned = (kind != MEM_NONE) && (in_op == OP_LW || in_op == OP_SW)
                        && (in_result[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst)
            addr_err_q <= 1'b0;
        else
            addr_err_q <= (state_q == IDLE) && in_valid && misaligned;
    end

    assign addr_err = addr_err_q;
`else
    assign addr_err = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        reg_write_d  = 1'b0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        lb_d         = lb_q;
        off_d        = off_q;
        dest_d       = dest_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (kind == MEM_NONE) begin
                        reg_write_d  = in_reg_write && (in_dest != REG_ZERO);
                        write_reg_d  = in_dest;
                        write_data_d = in_result;
                    end
`ifdef MEM_ALIGN_CHECK_EN
                    else if (misaligned) begin
                        // Dropped: no bus access, no write-back; addr_err
                        // is raised by its own register.
                    end
`endif
                    else begin
                        state_d     = ACCESS;
                        mem_req_d   = 1'b1;
                        mem_we_d    = (kind == MEM_STORE);
                        mem_addr_d  = {in_result[ADDR_W-1:2], 2'b00};
                        mem_be_d    = (kind == MEM_STORE) ? lane_be : 4'b1111;
                        mem_wdata_d = (kind == MEM_STORE) ? lane_wdata : '0;
                        lb_d        = (in_op == OP_LB);
                        off_d       = in_result[1:0];
                        dest_d      = in_dest;
                    end
                end
            end

            ACCESS: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (mem_we_q) begin
                        state_d = IDLE;
                    end else begin
                        // Load data is captured here so the write strobe
                        // is high during the WB cycle.
                        state_d      = WB;
                        reg_write_d  = (dest_q != REG_ZERO);
                        write_reg_d  = dest_q;
                        write_data_d = lane_load;
                    end
                end
            end

            WB: begin
                state_d = IDLE;
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase

        stall_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            stall_q      <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            lb_q         <= 1'b0;
            off_q        <= '0;
            dest_q       <= '0;
        end else begin
            state_q      <= state_d;
            stall_q      <= stall_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            lb_q         <= lb_d;
            off_q        <= off_d;
            dest_q       <= dest_d;
        end
    end

    assign stall      = stall_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;
    assign reg_write  = reg_write_q;
    assign write_reg  = write_reg_q;
    assign write_data = write_data_q;

endmodule

// File: tb/tb_mem_wb_unit.sv
// ----------------------------------------------------------------------------
// tb_mem_wb_unit
// Self-checking bench for mem_wb_unit. Inputs are driven on the falling edge,
// outputs sampled on the following falling edge. A transaction-level model
// (reference memory array plus byte arithmetic) predicts every bus request
// and register write; a separate responder memory is updated only by the
// DUT's own store traffic, so wrong stores surface as wrong later loads.
// ----------------------------------------------------------------------------
module tb_mem_wb_unit;
  import cpu_pkg::*;

  localparam int K_NONE  = 0;
  localparam int K_LOAD  = 1;
  localparam int K_STORE = 2;
  localparam int K_MIS   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [5:0]  in_op = '0;
  logic        in_reg_write = 1'b0;
  logic        in_mem_read = 1'b0;
  logic        in_mem_write = 1'b0;
  logic [4:0]  in_dest = '0;
  logic [31:0] in_result = '0;
  logic [31:0] in_store_data = '0;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        addr_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [16];
  logic [31:0] bus_mem [16];
  logic [37:0] exp_q [$];

  mem_wb_unit dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_op         (in_op),
    .in_reg_write  (in_reg_write),
    .in_mem_read   (in_mem_read),
    .in_mem_write  (in_mem_write),
    .in_dest       (in_dest),
    .in_result     (in_result),
    .in_store_data (in_store_data),
    .stall         (stall),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_be        (mem_be),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ack       (mem_ack),
    .reg_write     (reg_write),
    .write_reg     (write_reg),
    .write_data    (write_data),
    .addr_err      (addr_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int word_idx(input logic [31:0] addr);
    return int'((addr >> 2) & 32'd15);
  endfunction

  // Responder: apply a store exactly as the DUT's enables and data dictate.
  task automatic bus_write();
    int w;
    logic [31:0] cur;
    w = word_idx(mem_addr);
    cur = bus_mem[w];
    for (int b = 0; b < 4; b++)
      if (mem_be[b]) cur[8*b +: 8] = mem_wdata[8*b +: 8];
    bus_mem[w] = cur;
  endtask

  // Drive one instruction from IDLE (called at a falling edge) and check the
  // whole transaction, returning at a falling edge with the DUT idle again.
  task automatic run_instr(input logic [5:0] op, input logic rw, input logic mr,
                           input logic mw, input logic [4:0] dest,
                           input logic [31:0] result, input logic [31:0] sdata,
                           input int wait_cycles);
    int kind;
    int w;
    int off;
    logic [31:0] exp_data;
    logic [31:0] exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] b;
    logic exp_wb;

    check_eq("stall_idle", {31'd0, stall}, 32'd0);

    // Reference model: decide what the instruction should do.
    off = int'(result & 32'd3);
    w = word_idx(result);
    kind = K_NONE;
    if (mr && (op == OP_LW || op == OP_LB)) kind = K_LOAD;
    else if (mw && (op == OP_SW || op == OP_SB)) kind = K_STORE;
`ifdef MEM_ALIGN_CHECK_EN
    if (kind != K_NONE && (op == OP_LW || op == OP_SW) && off != 0) kind = K_MIS;
`endif
    exp_wb = 1'b0;
    exp_data = result;
    exp_be = 32'hF;
    exp_wdata = sdata;
    if (kind == K_NONE) begin
      exp_wb = rw && (dest != 5'd0);
    end else if (kind == K_LOAD) begin
      exp_wb = (dest != 5'd0);
      if (op == OP_LW) begin
        exp_data = ref_mem[w];
      end else begin
        b = (ref_mem[w] >> (8 * off)) & 32'hFF;
        exp_data = (b >= 32'd128) ? (b + 32'hFFFFFF00) : b;
      end
    end else if (kind == K_STORE) begin
      if (op == OP_SW) begin
        ref_mem[w] = sdata;
      end else begin
        exp_be = 32'd1 << off;
        exp_wdata = (sdata & 32'hFF) * 32'h01010101;
        ref_mem[w] = (ref_mem[w] & ~(32'hFF << (8 * off))) | ((sdata & 32'hFF) << (8 * off));
      end
    end

    // Idle-time ack noise must be ignored.
    mem_ack = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    in_op = op; in_reg_write = rw; in_mem_read = mr; in_mem_write = mw;
    in_dest = dest; in_result = result; in_store_data = sdata; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    mem_ack = 1'b0;

    if (kind == K_NONE) begin
      check_eq("alu_we", {31'd0, reg_write}, {31'd0, exp_wb});
      if (exp_wb) begin
        check_eq("alu_reg", {27'd0, write_reg}, {27'd0, dest});
        check_eq("alu_data", write_data, exp_data);
      end
      check_eq("alu_req", {31'd0, mem_req}, 32'd0);
      check_eq("alu_stall", {31'd0, stall}, 32'd0);
    end else if (kind == K_MIS) begin
      check_eq("mis_err", {31'd0, addr_err}, 32'd1);
      check_eq("mis_req", {31'd0, mem_req}, 32'd0);
      check_eq("mis_we", {31'd0, reg_write}, 32'd0);
      check_eq("mis_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      check_eq("mis_err_pulse", {31'd0, addr_err}, 32'd0);
    end else begin
      for (int k = 1; k <= wait_cycles; k++) begin
        check_eq("req_held", {31'd0, mem_req}, 32'd1);
        check_eq("req_addr", mem_addr, result & 32'hFFFFFFFC);
        check_eq("req_be", {28'd0, mem_be}, exp_be);
        check_eq("req_we", {31'd0, mem_we}, (kind == K_STORE) ? 32'd1 : 32'd0);
        if (kind == K_STORE) check_eq("req_wdata", mem_wdata, exp_wdata);
        check_eq("req_stall", {31'd0, stall}, 32'd1);
        check_eq("req_no_wb", {31'd0, reg_write}, 32'd0);
        if (k == wait_cycles) begin
          mem_ack = 1'b1;
          if (kind == K_STORE) bus_write();
          mem_rdata = bus_mem[word_idx(mem_addr)];
        end else begin
          mem_ack = 1'b0;
          mem_rdata = $urandom;
        end
        @(negedge clk);
      end
      mem_ack = 1'b0;
      check_eq("done_req", {31'd0, mem_req}, 32'd0);
      if (kind == K_LOAD) begin
        check_eq("ld_we", {31'd0, reg_write}, {31'd0, exp_wb});
        if (exp_wb) begin
          check_eq("ld_reg", {27'd0, write_reg}, {27'd0, dest});
          check_eq("ld_data", write_data, exp_data);
        end
        check_eq("ld_stall", {31'd0, stall}, 32'd1);
        @(negedge clk);
        check_eq("ld_pulse", {31'd0, reg_write}, 32'd0);
        check_eq("ld_stall_end", {31'd0, stall}, 32'd0);
      end else begin
        check_eq("st_no_wb", {31'd0, reg_write}, 32'd0);
        check_eq("st_stall", {31'd0, stall}, 32'd0);
      end
    end
  endtask

  task automatic preload(input int w, input logic [31:0] val);
    ref_mem[w] = val;
    bus_mem[w] = val;
  endtask

  initial begin
    int sel;
    logic [5:0] op;
    logic rw, mr, mw;
    logic [31:0] res;
    logic [37:0] e;

    for (int i = 0; i < 16; i++) preload(i, $urandom);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req", {31'd0, mem_req}, 32'd0);
    check_eq("rst_stall", {31'd0, stall}, 32'd0);
    check_eq("rst_we", {31'd0, reg_write}, 32'd0);
    check_eq("rst_memwe", {31'd0, mem_we}, 32'd0);
    check_eq("rst_err", {31'd0, addr_err}, 32'd0);
    check_eq("rst_addr", mem_addr, 32'd0);
    check_eq("rst_be", {28'd0, mem_be}, 32'd0);
    check_eq("rst_wdata", mem_wdata, 32'd0);
    check_eq("rst_wreg", {27'd0, write_reg}, 32'd0);
    check_eq("rst_wdata_rf", write_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases.
    run_instr(OP_SPECIAL, 1'b1, 1'b0, 1'b0, 5'd5, 32'h1234, 32'h0, 1);
    preload(0, 32'hDEADBEEF);
    run_instr(OP_LW, 1'b1, 1'b1, 1'b0, 5'd8, 32'h100, 32'h0, 3);
    preload(0, 32'h80000000);
    run_instr(OP_LB, 1'b1, 1'b1, 1'b0, 5'd9, 32'h103, 32'h0, 2);
    preload(0, 32'h007F0000);
    run_instr(OP_LB, 1'b1, 1'b1, 1'b0, 5'd10, 32'h102, 32'h0, 1);
    run_instr(OP_SB, 1'b0, 1'b0, 1'b1, 5'd0, 32'h201, 32'h000000AB, 2);
    run_instr(OP_LW, 1'b1, 1'b1, 1'b0, 5'd11, 32'h200, 32'h0, 1);
    run_instr(OP_SW, 1'b0, 1'b0, 1'b1, 5'd0, 32'h102, 32'h12345678, 2);
    run_instr(OP_LW, 1'b1, 1'b1, 1'b0, 5'd0, 32'h104, 32'h0, 2);

    // Back-to-back register ops: one result per cycle, never stalling.
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("b2b_stall", {31'd0, stall}, 32'd0);
        check_eq("b2b_we", {31'd0, reg_write}, {31'd0, e[37]});
        if (e[37]) begin
          check_eq("b2b_reg", {27'd0, write_reg}, {27'd0, e[36:32]});
          check_eq("b2b_data", write_data, e[31:0]);
        end
      end
      in_op = OP_SPECIAL; in_mem_read = 1'b0; in_mem_write = 1'b0;
      in_reg_write = 1'($urandom_range(0, 1));
      in_dest = 5'($urandom_range(0, 31));
      in_result = $urandom;
      in_valid = 1'b1;
      exp_q.push_back({in_reg_write && (in_dest != 5'd0), in_dest, in_result});
      @(negedge clk);
    end
    in_valid = 1'b0;
    e = exp_q.pop_front();
    check_eq("b2b_last_we", {31'd0, reg_write}, {31'd0, e[37]});
    if (e[37]) check_eq("b2b_last_data", write_data, e[31:0]);
    @(negedge clk);

    // Randomized instruction mix.
    for (int n = 0; n < 250; n++) begin
      sel = $urandom_range(0, 6);
      rw = 1'b1; mr = 1'b0; mw = 1'b0;
      res = 32'h100 + (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(0, 3));
      case (sel)
        0: begin op = OP_SPECIAL; rw = 1'($urandom_range(0, 1)); res = $urandom; end
        1: begin op = OP_LW; mr = 1'b1; end
        2: begin op = OP_LB; mr = 1'b1; end
        3: begin op = OP_SW; mw = 1'b1; rw = 1'b0; end
        4: begin op = OP_SB; mw = 1'b1; rw = 1'b0; end
        5: begin
          op = 6'b001000; rw = 1'($urandom_range(0, 1));
          mr = 1'($urandom_range(0, 1)); mw = ~mr;
        end
        default: begin op = ($urandom_range(0, 1) != 0) ? OP_LW : OP_LB; mr = 1'b1; mw = 1'b1; end
      endcase
      run_instr(op, rw, mr, mw, 5'($urandom_range(0, 31)), res, $urandom,
                $urandom_range(1, 4));
    end

    // Reset in the middle of a dest=0 load discards it.
    in_op = OP_LW; in_reg_write = 1'b1; in_mem_read = 1'b1; in_mem_write = 1'b0;
    in_dest = 5'd0; in_result = 32'h108; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("rstmid_req", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rstmid_req_drop", {31'd0, mem_req}, 32'd0);
    check_eq("rstmid_stall", {31'd0, stall}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      mem_ack = 1'b1;
      @(negedge clk);
      check_eq("rstmid_no_wb", {31'd0, reg_write}, 32'd0);
      check_eq("rstmid_no_req", {31'd0, mem_req}, 32'd0);
    end
    mem_ack = 1'b0;

    // The unit must be fully usable after the mid-access reset.
    run_instr(OP_LW, 1'b1, 1'b1, 1'b0, 5'd3, 32'h10C, 32'h0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_unit.md
Name: mem_wb_unit

Overview:
- Memory-access and write-back stage of the MIPS pipeline.
- Accepts one executed instruction per handshake from EX.
- Performs LW/LB/SW/SB over a single-outstanding req/ack data-memory bus.
- Drives the register-file write port (reg_write, write_reg, write_data) back into the decode stage. It is the producer end of the port the decode stage consumes.

Parameters:
- ADDR_W, 32, data-memory byte-address width.
- DATA_W, 32, data word width; fixed at 32 for the MIPS subset.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  EX presents an instruction.
- in_op  in  6  opcode (ins[31:26]).
- in_reg_write  in  1  instruction writes a register (ALU result or load).
- in_mem_read  in  1  load.
- in_mem_write  in  1  store.
- in_dest  in  5  destination register.
- in_result  in  32  ALU result; effective address for loads and stores.
- in_store_data  in  32  rt value for stores.
- stall  out  1  high: in_valid ignored, EX must hold.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = store.
- mem_addr  out  ADDR_W  word-aligned address ({in_result[31:2],2'b00}).
- mem_be  out  4  byte enables.
- mem_wdata  out  32  store data, byte-replicated for SB.
- mem_rdata  in  32  read data, valid with mem_ack.
- mem_ack  in  1  completes the request; sampled only while mem_req = 1.
- reg_write  out  1  one-cycle write strobe to the register file.
- write_reg  out  5  destination.
- write_data  out  32  write value.
- addr_err  out  1  misalignment flag (optional feature only; tied 0 otherwise).

Behaviour:
- Reset: state IDLE.
  - mem_req, mem_we, reg_write, stall, addr_err = 0.
  - mem_addr, mem_be, mem_wdata, write_reg, write_data = 0.
  - Reset asserted mid-access drops mem_req at that edge and discards the pending op; no write-back.
- All outputs are registered. stall = (state != IDLE).
- State IDLE:
  - in_valid=1, non-memory op: next cycle reg_write = in_reg_write && (in_dest != 0), write_reg = in_dest, write_data = in_result. Stays IDLE; 1-cycle latency, full throughput.
  - in_valid=1, in_mem_read or in_mem_write: latch op, byte offset, dest. Next cycle mem_req=1 with addr/be/we/wdata. Go to ACCESS.
- State ACCESS: hold mem_req and all bus outputs stable until mem_ack=1 at an edge.
  - Load completes: go to WB.
  - Store completes: drop mem_req, return to IDLE; no register write.
- State WB: pulse reg_write for one cycle (suppressed if dest = 0) with formatted load data, then IDLE.
  - New input is accepted in the cycle after WB, so load latency = 1 + wait + 1 cycles.
- Byte lanes are little-endian: offset k selects bits [8k+7:8k].
  - LW: be=4'b1111.
  - LB: be=4'b1111 (full word read); result = sign-extended selected byte.
  - SW: be=4'b1111, wdata=store_data.
  - SB: be=1<<offset, wdata={4{store_data[7:0]}}.
- Any in_op with in_mem_read/in_mem_write set other than these four is treated as a non-memory op.
- mem_ack while mem_req=0 is ignored.
- in_mem_read and in_mem_write both set: read takes priority.

Optional Feature:
- MEM_ALIGN_CHECK_EN defined:
  - LW/SW with in_result[1:0] != 0 performs no bus access and no write-back.
  - addr_err pulses 1 cycle; state stays IDLE.
  - LB/SB are never misaligned.
- Not defined: the address low bits are dropped for word ops, access proceeds, and addr_err is constant 0.

Decomposition:
- Shared package (cpu_pkg): opcode constants OP_LW=6'b100011, OP_LB=6'b100000, OP_SW=6'b101011, OP_SB=6'b101000, OP_SPECIAL; state enum IDLE/ACCESS/WB; REG_ZERO=5'd0.
- One natural sub-module: mem_byte_lane. Combinational; generates be/wdata for stores and extracts/sign-extends load data from the offset.

Test Plan:
- ALU op: in_reg_write=1, dest=5, result=0x1234 -> next cycle reg_write=1, write_reg=5, write_data=0x1234. Back-to-back ops every cycle with no stall.
- LW at 0x100, ack after 3 cycles with rdata=0xDEADBEEF -> mem_req held 3 cycles with addr 0x100, be=F. Then one reg_write pulse with 0xDEADBEEF. stall high throughout.
- LB at 0x103, rdata=0x80000000 -> write_data=0xFFFFFF80. LB at 0x102, rdata=0x007F0000 -> 0x0000007F.
- SB at 0x201, store_data=0xAB -> be=4'b0010, wdata=0xABABABAB, mem_we=1. No reg_write after ack.
- Dest=0 load, then rst pulsed during ACCESS -> reg_write never asserted; mem_req=0 the cycle after rst.
- With MEM_ALIGN_CHECK_EN: SW at 0x102 -> addr_err=1 for one cycle, mem_req stays 0.
